// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM stage.
// Holds the port FSM state enum, bus widths and alignment helper.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mem_state_t;

  function automatic logic is_misaligned(
    input logic [1:0] a
  );
    return |(a & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory req/ready bus.
// master: unit side (req/we/addr/wdata out); slave: memory side.
interface mem_access_unit_if
  import mem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic          dmem_ready;
  logic [DW-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ready,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ready,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_access_unit_dmem_port_fsm.sv
// dmem_port_fsm: IDLE/BUSY/DONE access sequencer and bus registers.
// Ports: clk, rst, i_acc/i_we/i_addr/i_wdata, bus (master),
// o_stall, o_misalign, o_rdata. Macro: MEM_ALIGN_CHECK_EN.
module dmem_port_fsm
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_acc,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  mem_access_unit_if.master bus,
  output logic              o_stall,
  output logic              o_misalign,
  output logic [DATA_W-1:0] o_rdata
);

  mem_state_t r_state;
  mem_state_t w_state_nxt;

  logic              w_start;
  logic              w_done;
  logic              w_misalign;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_misalign  = 1'b0;
    o_stall     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_acc) begin
`ifdef MEM_ALIGN_CHECK_EN
          w_misalign = is_misaligned(i_addr[1:0]);
`endif
          // a rejected access is dropped without stalling
          if (!w_misalign) begin
            o_stall     = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        o_stall = 1'b1;
        if (bus.dmem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // never stall here: EX/MEM must advance
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_start) begin
      r_req   <= 1'b1;
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end else if (w_done) begin
      r_req <= 1'b0;
      if (!r_we) begin
        r_rdata <= bus.dmem_rdata;
      end
    end
  end

  assign bus.dmem_req   = r_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = r_addr;
  assign bus.dmem_wdata = r_wdata;
  assign o_misalign     = w_misalign;
  assign o_rdata        = r_rdata;

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage - load/store sequencing, branch resolve.
// Ports: clk, rst, EX/MEM inputs (*_in), dmem bus (master),
// stall, pc_src/pc_target, MEM/WB outputs. Macro: MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       branch_target_in,
  input  logic [31:0]       reg_data2_fwd_in,
  input  logic [4:0]        rd_addr_final_in,
  input  logic              zero_flag_in,
  input  logic              branch_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  mem_access_unit_if.master dmem,
  output logic              mem_stall,
  output logic              pc_src,
  output logic [31:0]       pc_target,
  output logic [31:0]       alu_result_out,
  output logic [4:0]        rd_addr_out,
  output logic              mem_to_reg_out,
  output logic              reg_write_out,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              mem_misalign
);

  logic w_acc;
  logic w_stall;
  logic w_misalign;

  assign w_acc = mem_read_in | mem_write_in;

  dmem_port_fsm u_port (
    .clk        (clk),
    .rst        (rst),
    .i_acc      (w_acc),
    .i_we       (mem_write_in),
    .i_addr     (alu_result_in),
    .i_wdata    (reg_data2_fwd_in),
    .bus        (dmem),
    .o_stall    (w_stall),
    .o_misalign (w_misalign),
    .o_rdata    (mem_rdata_out)
  );

  assign mem_stall    = w_stall;
  assign mem_misalign = w_misalign;

  assign pc_src    = branch_in & zero_flag_in;
  assign pc_target = branch_target_in;

  assign alu_result_out = alu_result_in;
  assign rd_addr_out    = rd_addr_final_in;
  assign mem_to_reg_out = mem_to_reg_in;
  // stalled or faulting cycles become bubbles in MEM/WB
  assign reg_write_out  = reg_write_in & ~w_stall & ~w_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench with transaction-level model.
// Honors MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_in;
  logic [31:0] branch_target_in;
  logic [31:0] reg_data2_fwd_in;
  logic [4:0]  rd_addr_final_in;
  logic        zero_flag_in;
  logic        branch_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic        mem_stall;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] alu_result_out;
  logic [4:0]  rd_addr_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic [31:0] mem_rdata_out;
  logic        mem_misalign;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata;

  mem_access_unit_if bus ();

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk              (clk),
    .rst              (rst),
    .alu_result_in    (alu_result_in),
    .branch_target_in (branch_target_in),
    .reg_data2_fwd_in (reg_data2_fwd_in),
    .rd_addr_final_in (rd_addr_final_in),
    .zero_flag_in     (zero_flag_in),
    .branch_in        (branch_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .mem_to_reg_in    (mem_to_reg_in),
    .reg_write_in     (reg_write_in),
    .dmem             (bus),
    .mem_stall        (mem_stall),
    .pc_src           (pc_src),
    .pc_target        (pc_target),
    .alu_result_out   (alu_result_out),
    .rd_addr_out      (rd_addr_out),
    .mem_to_reg_out   (mem_to_reg_out),
    .reg_write_out    (reg_write_out),
    .mem_rdata_out    (mem_rdata_out),
    .mem_misalign     (mem_misalign)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mis(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
  endfunction

  // non-memory instruction: single cycle, no stall
  task automatic run_alu(
    input logic [31:0] res,
    input logic [31:0] tgt,
    input logic [4:0]  rd,
    input bit          br,
    input bit          z,
    input bit          m2r,
    input bit          rw
  );
    alu_result_in    = res;
    branch_target_in = tgt;
    reg_data2_fwd_in = $urandom;
    rd_addr_final_in = rd;
    branch_in        = br;
    zero_flag_in     = z;
    mem_read_in      = 1'b0;
    mem_write_in     = 1'b0;
    mem_to_reg_in    = m2r;
    reg_write_in     = rw;
    bus.dmem_ready   = 1'($urandom_range(0, 1));
    bus.dmem_rdata   = $urandom;
    #1;
    chk("alu_stall", mem_stall, 0);
    chk("alu_req", bus.dmem_req, 0);
    chk("pc_src", pc_src, br & z);
    chk("pc_target", pc_target, tgt);
    chk("alu_out", alu_result_out, res);
    chk("rd_out", rd_addr_out, rd);
    chk("m2r_out", mem_to_reg_out, m2r);
    chk("alu_rw", reg_write_out, rw);
    chk("alu_misal", mem_misalign, 0);
    chk("alu_rdata", mem_rdata_out, exp_rdata);
    @(negedge clk);
  endtask

  // memory instruction: ready arrives after w extra BUSY cycles
  task automatic run_mem(
    input bit          we,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] rdata,
    input logic [4:0]  rd,
    input bit          rw,
    input int          w
  );
    int stall_n;
    int req_n;
    bit done;
    alu_result_in    = addr;
    branch_target_in = $urandom;
    reg_data2_fwd_in = wdata;
    rd_addr_final_in = rd;
    branch_in        = 1'b0;
    zero_flag_in     = 1'($urandom_range(0, 1));
    mem_read_in      = ~we;
    mem_write_in     = we;
    mem_to_reg_in    = ~we;
    reg_write_in     = rw;
    bus.dmem_ready   = 1'($urandom_range(0, 1));
    if (mis(addr)) begin
      #1;
      chk("mis_flag", mem_misalign, 1);
      chk("mis_stall", mem_stall, 0);
      chk("mis_req", bus.dmem_req, 0);
      chk("mis_rw", reg_write_out, 0);
      @(negedge clk);
      return;
    end
    stall_n = 0;
    req_n   = 0;
    done    = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (c == 0) chk("misal0", mem_misalign, 0);
      chk("m_pc_src", pc_src, 0);
      if (mem_stall) begin
        stall_n++;
        chk("rw_bubble", reg_write_out, 0);
      end else begin
        done = 1'b1;
        if (!we) exp_rdata = rdata;
        chk("rdata", mem_rdata_out, exp_rdata);
        chk("rw_done", reg_write_out, rw);
        chk("req_done", bus.dmem_req, 0);
        chk("m_alu_out", alu_result_out, addr);
        chk("m_rd_out", rd_addr_out, rd);
      end
      if (bus.dmem_req) begin
        req_n++;
        chk("addr", bus.dmem_addr, addr);
        chk("we", bus.dmem_we, we);
        if (we) chk("wdata", bus.dmem_wdata, wdata);
      end
      if (bus.dmem_req) begin
        bus.dmem_ready = (req_n == w + 1);
        bus.dmem_rdata = rdata;
      end else begin
        bus.dmem_ready = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
      @(negedge clk);
    end
    chk("done", done, 1);
    chk("stall_n", stall_n, 2 + w);
    chk("req_n", req_n, 1 + w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    alu_result_in    = '0;
    branch_target_in = '0;
    reg_data2_fwd_in = '0;
    rd_addr_final_in = '0;
    zero_flag_in     = 1'b0;
    branch_in        = 1'b0;
    mem_read_in      = 1'b0;
    mem_write_in     = 1'b0;
    mem_to_reg_in    = 1'b0;
    reg_write_in     = 1'b0;
    bus.dmem_ready   = 1'b0;
    bus.dmem_rdata   = '0;
    exp_rdata        = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_rdata", mem_rdata_out, 0);
    chk("rst_stall", mem_stall, 0);
    @(negedge clk);
    rst = 1'b0;

    run_mem(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 5'd5, 1'b1, 0);
    run_mem(1'b1, 32'h100, 32'h1234_5678, 32'hCAFE_F00D, 5'd0, 1'b0, 3);
    run_alu(32'h7, 32'h200, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    run_alu(32'h7, 32'h200, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    run_mem(1'b0, 32'h80, 32'h0, 32'h1111_2222, 5'd7, 1'b1, 1);
    run_mem(1'b0, 32'h84, 32'h0, 32'h3333_4444, 5'd8, 1'b1, 0);

    alu_result_in = 32'h200;
    mem_read_in   = 1'b1;
    mem_write_in  = 1'b0;
    reg_write_in  = 1'b1;
    bus.dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_req", bus.dmem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus.dmem_req, 0);
    chk("arst_addr", bus.dmem_addr, 0);
    chk("arst_rdata", mem_rdata_out, 0);
    exp_rdata   = '0;
    mem_read_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_mem(1'b0, 32'h44, 32'h0, 32'h5555_6666, 5'd9, 1'b1, 2);

    run_mem(1'b0, 32'h42, 32'h0, 32'h7777_8888, 5'd10, 1'b1, 0);

    repeat (300) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 9) < 4) begin
        run_alu($urandom, $urandom, 5'($urandom),
                1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom));
      end else begin
        run_mem(1'($urandom), a, $urandom, $urandom,
                5'($urandom), 1'($urandom),
                $urandom_range(0, 4));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
